// File: rtl/conv_col_sequencer.sv
// Column sequencer for the column-convolution engine: fetches columns, inserts
// zero pads, primes/steps the engine and streams results with valid/ready.
module conv_col_sequencer #(
  parameter int IMG_WIDTH  = 120,
  parameter int IMG_HEIGHT = 120,
  parameter int IMG_NB     = 7,
  parameter int RES_W      = 9120,
  parameter int ENG_LAT    = 1,
  parameter int ADDR_NB    = 7
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_rd_en,
  output logic [ADDR_NB-1:0]           o_rd_addr,
  input  logic [IMG_HEIGHT*IMG_NB-1:0] i_rd_data,
  output logic [IMG_HEIGHT*IMG_NB-1:0] o_eng_col,
  output logic                         o_eng_fill,
  output logic                         o_eng_step,
  input  logic [RES_W-1:0]             i_eng_result,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [RES_W-1:0]             o_out_data,
  output logic [ADDR_NB-1:0]           o_out_idx
);

  localparam int LAT_NB = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;
  localparam logic [ADDR_NB:0]   LAST_COL  = (ADDR_NB+1)'(IMG_WIDTH - 1);
  localparam logic [ADDR_NB-1:0] LAST_K    = ADDR_NB'(IMG_WIDTH - 1);
  localparam logic [LAT_NB-1:0]  LAST_WAIT = LAT_NB'(ENG_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, EMIT, DONE} state_t;

  state_t              state_r, state_nxt;
  logic                prime_r, prime_nxt;
  logic [1:0]          p_r, p_nxt;
  logic [ADDR_NB-1:0]  k_r, k_nxt;
  logic [LAT_NB-1:0]   wait_r, wait_nxt;
  logic                img_r;
  logic                capture_s;
  logic [ADDR_NB:0]    src_nxt;

  // Returns {is_image, column_index} for the slot selected by phase and counters.
  function automatic logic [ADDR_NB:0] col_src(input logic prime, input logic [1:0] p,
                                               input logic [ADDR_NB-1:0] k);
    logic [ADDR_NB:0] ahead;
    col_src = {1'b0, {ADDR_NB{1'b0}}};
    ahead   = {1'b0, k} + (ADDR_NB+1)'(2);
    if (prime) begin
      if (p == 2'd0) col_src = {1'b0, {ADDR_NB{1'b0}}};
      else           col_src = {1'b1, ADDR_NB'(p) - ADDR_NB'(1)};
    end else begin
      if (ahead <= LAST_COL) col_src = {1'b1, ahead[ADDR_NB-1:0]};
      else                   col_src = {1'b0, {ADDR_NB{1'b0}}};
    end
  endfunction

  // Next-state and counter update logic.
  always_comb begin
    state_nxt = state_r;
    prime_nxt = prime_r;
    p_nxt     = p_r;
    k_nxt     = k_r;
    wait_nxt  = wait_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_nxt = FETCH;
          prime_nxt = 1'b1;
          p_nxt     = 2'd0;
          k_nxt     = {ADDR_NB{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      FETCH: state_nxt = LATCH;
      LATCH: state_nxt = ISSUE;
      ISSUE: begin
        if (prime_r) begin
          state_nxt = FETCH;
          if (p_r == 2'd2) begin
            prime_nxt = 1'b0;
            k_nxt     = {ADDR_NB{1'b0}};
          end else begin
            p_nxt = p_r + 2'd1;
          end
        end else begin
          state_nxt = WAIT;
          wait_nxt  = {LAT_NB{1'b0}};
        end
      end
      WAIT: begin
        if (wait_r == LAST_WAIT) begin
          state_nxt = EMIT;
          capture_s = 1'b1;
        end else begin
          wait_nxt = wait_r + LAT_NB'(1);
        end
      end
      EMIT: begin
        // The next step waits for acceptance, so the held result is never overwritten.
        if (i_out_ready) begin
          if (k_r == LAST_K) begin
            state_nxt = DONE;
          end else begin
            k_nxt     = k_r + ADDR_NB'(1);
            state_nxt = FETCH;
          end
        end else begin
          state_nxt = EMIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    src_nxt = col_src(prime_nxt, p_nxt, k_nxt);
  end

  // State, counters and all outputs registered from the next-state decode.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_r     <= IDLE;
      prime_r     <= 1'b0;
      p_r         <= 2'd0;
      k_r         <= {ADDR_NB{1'b0}};
      wait_r      <= {LAT_NB{1'b0}};
      img_r       <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= {ADDR_NB{1'b0}};
      o_eng_col   <= {(IMG_HEIGHT*IMG_NB){1'b0}};
      o_eng_fill  <= 1'b0;
      o_eng_step  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_data  <= {RES_W{1'b0}};
      o_out_idx   <= {ADDR_NB{1'b0}};
    end else begin
      state_r     <= state_nxt;
      prime_r     <= prime_nxt;
      p_r         <= p_nxt;
      k_r         <= k_nxt;
      wait_r      <= wait_nxt;
      o_busy      <= (state_nxt != IDLE);
      o_done      <= (state_nxt == DONE);
      o_rd_en     <= (state_nxt == FETCH) && src_nxt[ADDR_NB];
      o_eng_fill  <= (state_nxt == ISSUE) && prime_nxt;
      o_eng_step  <= (state_nxt == ISSUE) && !prime_nxt;
      o_out_valid <= (state_nxt == EMIT);
      if (state_nxt == FETCH) begin
        img_r <= src_nxt[ADDR_NB];
        if (src_nxt[ADDR_NB]) o_rd_addr <= src_nxt[ADDR_NB-1:0];
      end
      if (state_r == LATCH) begin
        o_eng_col <= img_r ? i_rd_data : {(IMG_HEIGHT*IMG_NB){1'b0}};
      end
      if (capture_s) begin
        o_out_data <= i_eng_result;
        o_out_idx  <= k_r;
      end
    end
  end

endmodule

// File: tb/tb_conv_col_sequencer.sv
// Bench for conv_col_sequencer: two instances (ENG_LAT 1 and 3) with RAM and
// tagging engine models; scenario table plus reset and restart sequences.
module tb_conv_col_sequencer;
  localparam int W = 4, H = 2, NB = 4, CW = H * NB, RW = 16, AN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, tag_clr;
  logic [1:0] ready, busy, done, rd_en, fill, step, valid;
  logic [AN-1:0] rd_addr [2];
  logic [AN-1:0] out_idx [2];
  logic [CW-1:0] rd_data [2];
  logic [CW-1:0] eng_col [2];
  logic [RW-1:0] eng_res [2];
  logic [RW-1:0] out_data [2];

  conv_col_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .IMG_NB(NB), .RES_W(RW),
                       .ENG_LAT(1), .ADDR_NB(AN)) dut1 (
    .clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy[0]), .o_done(done[0]),
    .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]), .i_rd_data(rd_data[0]),
    .o_eng_col(eng_col[0]), .o_eng_fill(fill[0]), .o_eng_step(step[0]),
    .i_eng_result(eng_res[0]), .o_out_valid(valid[0]), .i_out_ready(ready[0]),
    .o_out_data(out_data[0]), .o_out_idx(out_idx[0]));

  conv_col_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .IMG_NB(NB), .RES_W(RW),
                       .ENG_LAT(3), .ADDR_NB(AN)) dut3 (
    .clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy[1]), .o_done(done[1]),
    .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]), .i_rd_data(rd_data[1]),
    .o_eng_col(eng_col[1]), .o_eng_fill(fill[1]), .o_eng_step(step[1]),
    .i_eng_result(eng_res[1]), .o_out_valid(valid[1]), .i_out_ready(ready[1]),
    .o_out_data(out_data[1]), .o_out_idx(out_idx[1]));

  // RAM holds value j+1 in column j; engine result = {cycle count, step tag}.
  int cyc = 0;
  logic [7:0] tag [2];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) rd_data[i] <= CW'(rd_addr[i]) + CW'(1);
      if (tag_clr) tag[i] <= 8'd0;
      else if (step[i]) tag[i] <= tag[i] + 8'd1;
    end
  end
  assign eng_res[0] = {cyc[7:0], tag[0]};
  assign eng_res[1] = {cyc[7:0], tag[1]};

  typedef struct {
    int stall_out;
    int stall_len;
    bit spam;
    int exp_done;
  } scen_t;
  scen_t scen [4];

  int checks = 0, failures = 0, errs;
  int n_rd[2], rd_log[2][8], n_fill[2], fill_rel[2][4], fill_col[2][4];
  int n_step[2], step_rel[2][8], step_col[2][8], step_cyc[2][8];
  int n_out[2], o_idx[2][8], o_dat[2][8], vrise[2][8], done_rel[2];
  logic [1:0] pvalid, pacc;
  logic [RW-1:0] pdata [2];
  logic [AN-1:0] pidx [2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_flags"}, {busy[i], done[i], rd_en[i], fill[i], step[i], valid[i]}, 0);
      chk({name, "_data"}, {rd_addr[i], eng_col[i], out_data[i], out_idx[i]}, 0);
    end
  endtask

  task automatic sample(input int rel);
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i] && n_rd[i] < 8) begin rd_log[i][n_rd[i]] = int'(rd_addr[i]); n_rd[i]++; end
      if (fill[i] && n_fill[i] < 4) begin
        fill_rel[i][n_fill[i]] = rel; fill_col[i][n_fill[i]] = int'(eng_col[i]); n_fill[i]++;
      end
      if (step[i] && n_step[i] < 8) begin
        step_rel[i][n_step[i]] = rel; step_col[i][n_step[i]] = int'(eng_col[i]);
        step_cyc[i][n_step[i]] = cyc; n_step[i]++;
      end
      if ((fill[i] && step[i]) || ((fill[i] || step[i]) && valid[i])) errs++;
      if (done_rel[i] < 0 && !busy[i]) errs++;
      if (pvalid[i] && !pacc[i] && (!valid[i] || out_data[i] != pdata[i] || out_idx[i] != pidx[i])) errs++;
      if (valid[i] && !pvalid[i] && n_out[i] < 8) vrise[i][n_out[i]] = rel;
      if (done[i]) begin
        if (done_rel[i] < 0) done_rel[i] = rel;
        else errs++;
      end
    end
  endtask

  task automatic run_frame(input scen_t s, input string tag_name);
    int rel, stall_left;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_rd[i] = 0; n_fill[i] = 0; n_step[i] = 0; n_out[i] = 0; done_rel[i] = -1;
    end
    errs = 0; pvalid = 2'b00; pacc = 2'b00;
    start = 1'b1; tag_clr = 1'b1; ready = 2'b11; rel = 0; stall_left = s.stall_len;
    while ((done_rel[0] < 0 || done_rel[1] < 0) && rel < 150) begin
      tick(); rel++;
      start = 1'b0; tag_clr = 1'b0;
      sample(rel);
      ready = 2'b11;
      if (valid[0] && int'(out_idx[0]) == s.stall_out && stall_left > 0) begin
        ready[0] = 1'b0; stall_left--;
      end
      for (int i = 0; i < 2; i++) begin
        if (valid[i] && ready[i] && n_out[i] < 8) begin
          o_idx[i][n_out[i]] = int'(out_idx[i]); o_dat[i][n_out[i]] = int'(out_data[i]); n_out[i]++;
        end
        pvalid[i] = valid[i]; pacc[i] = valid[i] & ready[i];
        pdata[i] = out_data[i]; pidx[i] = out_idx[i];
      end
      if (s.spam) start = busy[0] && busy[1];
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 1 : 3;
      chk({tag_name, "_rd_count"}, n_rd[i], W);
      for (int j = 0; j < W; j++) chk({tag_name, "_rd_addr"}, rd_log[i][j], j);
      chk({tag_name, "_fill_count"}, n_fill[i], 3);
      for (int j = 0; j < 3; j++) begin
        chk({tag_name, "_fill_cycle"}, fill_rel[i][j], 3 + 3 * j);
        chk({tag_name, "_fill_col"}, fill_col[i][j], j);
      end
      chk({tag_name, "_step_count"}, n_step[i], W);
      chk({tag_name, "_first_step"}, step_rel[i][0], 12);
      for (int j = 0; j < W; j++) chk({tag_name, "_step_col"}, step_col[i][j], (j < 2) ? j + 3 : 0);
      chk({tag_name, "_out_count"}, n_out[i], W);
      for (int j = 0; j < W; j++) begin
        chk({tag_name, "_out_idx"}, o_idx[i][j], j);
        chk({tag_name, "_out_data"}, o_dat[i][j], ((step_cyc[i][j] + lat) % 256) * 256 + j + 1);
        chk({tag_name, "_step_to_valid"}, vrise[i][j] - step_rel[i][j], lat + 1);
      end
      chk({tag_name, "_done_cycle"}, done_rel[i], (i == 0) ? s.exp_done : 10 + W * 7);
    end
    chk({tag_name, "_protocol_errors"}, errs, 0);
  endtask

  initial begin
    bit dn, bz;
    scen[0] = '{-1, 0, 1'b0, 30};
    scen[1] = '{ 2, 5, 1'b0, 35};
    scen[2] = '{ 0, 2, 1'b1, 32};
    scen[3] = '{ 3, 1, 1'b1, 31};
    rst = 1'b1; start = 1'b0; tag_clr = 1'b0; ready = 2'b11;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    for (int s = 0; s < 4; s++) run_frame(scen[s], $sformatf("scen%0d", s));

    // Reset during WAIT of step 1, then a clean frame.
    tick();
    start = 1'b1; tag_clr = 1'b1;
    for (int r = 1; r <= 17; r++) begin
      tick(); start = 1'b0; tag_clr = 1'b0;
    end
    chk("step1_before_reset", step[0], 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("reset_mid");
    dn = 1'b0; bz = 1'b0;
    repeat (6) begin
      tick();
      dn |= |done; bz |= |busy;
    end
    chk("no_done_after_reset", dn, 0);
    chk("idle_after_reset", bz, 0);
    run_frame(scen[0], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_col_sequencer.md
# conv_col_sequencer

Column sequencer for the column-convolution engine. It fetches image columns from the column buffer RAM and inserts the left and right zero-pad columns. It drives the engine's prime-fill and compute-step strobes, then streams each output column to the downstream writer with valid/ready backpressure. It is the only master of the engine's column input and control strobes.

## Interface
- IMG_WIDTH, 120: image columns per frame (outputs per frame); must be ≥ 2
- IMG_HEIGHT, 120: pixels per column
- IMG_NB, 7: bits per pixel
- RES_W, 9120: engine result column width, bits
- ENG_LAT, 1: cycles from step strobe to valid engine result; must be ≥ 1
- ADDR_NB, 7: column RAM address width, must hold IMG_WIDTH-1
- clock  in  1  single clock; all logic on posedge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  frame start pulse, honoured only in IDLE
- o_busy  out  1  high from the cycle after an accepted start through DONE inclusive
- o_done  out  1  one-cycle pulse in DONE
- o_rd_en  out  1  column RAM read enable
- o_rd_addr  out  ADDR_NB  column RAM address
- i_rd_data  in  IMG_HEIGHT*IMG_NB  RAM data, valid the cycle after o_rd_en
- o_eng_col  out  IMG_HEIGHT*IMG_NB  column presented to the engine
- o_eng_fill  out  1  prime-load strobe: the engine stores o_eng_col into its next prime slot
- o_eng_step  out  1  compute strobe: the engine convolves its 3 held columns and loads o_eng_col
- i_eng_result  in  RES_W  engine output column
- o_out_valid  out  1  output column valid
- i_out_ready  in  1  downstream accept
- o_out_data  out  RES_W  registered output column
- o_out_idx  out  ADDR_NB  index of the output column, 0..IMG_WIDTH-1

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, EMIT, DONE. Phase flag PRIME/RUN; prime counter p in 0..2; step counter k in 0..IMG_WIDTH-1.
- IDLE: on i_start, clear p and k, set PRIME, go to FETCH. i_start is ignored in every other state.
- Column source for the current slot:
  - PRIME p=0: zero pad.
  - PRIME p=1,2: image column p-1.
  - RUN step k: image column k+2 if k+2 ≤ IMG_WIDTH-1, else zero.
- FETCH: for an image column, o_rd_en=1 and o_rd_addr=column index. For a pad column, o_rd_en=0. Always 1 cycle, then LATCH.
- LATCH: register i_rd_data into o_eng_col, or register 0 for a pad column. Go to ISSUE.
- ISSUE, 1 cycle:
  - PRIME: o_eng_fill=1. If p=2, switch to RUN with k=0; otherwise p++. Go to FETCH.
  - RUN: o_eng_step=1. Go to WAIT.
- WAIT: ENG_LAT cycles. On the last cycle, capture i_eng_result into o_out_data and k into o_out_idx. Go to EMIT.
- EMIT: o_out_valid=1; o_out_data and o_out_idx stay stable until accepted.
  - On i_out_ready: if k=IMG_WIDTH-1, go to DONE; otherwise k++ and go to FETCH.
  - The next step is never issued before acceptance, so no result is overwritten.
- DONE: o_done=1, then IDLE.
- Output k is the convolution of image columns k-1, k and k+1, with column -1 and column IMG_WIDTH as zero.
- o_eng_fill and o_eng_step are never high together, and each is high only in ISSUE.

## Timing
- Reset values: o_busy, o_done, o_rd_en, o_eng_fill, o_eng_step and o_out_valid are 0. o_rd_addr, o_eng_col, o_out_data and o_out_idx are 0. State is IDLE, counters are 0.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. A pending output is dropped, and no o_done is produced.
- Start accepted in cycle t: FETCH in t+1, first o_eng_fill in t+3, further fills in t+6 and t+9, first o_eng_step in t+12.
- A step at cycle c gives o_out_valid from c+ENG_LAT+1. With i_out_ready held high, steps are (4+ENG_LAT) cycles apart.
- With continuous ready, o_done falls at t+1+9+IMG_WIDTH*(4+ENG_LAT). Each cycle of ready low adds exactly 1 cycle.
- i_start coincident with DONE or the final EMIT acceptance is ignored.

## Test plan
- IMG_WIDTH=4, ENG_LAT=1, RAM column j filled with value j+1, ready high:
  - o_rd_addr sequence 0,1,2,3; no reads for the pads.
  - Fills at t+3, t+6 and t+9 carry 0, col0, col1; steps carry col2, col3, 0, 0.
  - 4 outputs with idx 0..3; o_done at t+30.
- Engine model returns a step-count tag: o_out_data values equal tags 1..4 in order, none duplicated or skipped.
- Hold i_out_ready low for 5 cycles on output 2: valid, data and idx stay stable; no o_eng_step during the stall; o_done 5 cycles later than the ready-high run.
- ENG_LAT=3: each step-to-valid gap is 4 cycles and the data equals the engine value sampled 3 cycles after the step.
- Assert i_reset during WAIT of step 1: all outputs 0 the next cycle and no o_done. A new i_start then runs the full sequence correctly.
- Pulse i_start repeatedly while busy: no restart and identical output sequence; back-to-back frames with start in the cycle after DONE both complete.
